// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR MAC scheduler and its arbiter.
package fir_sched_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_NUM_TAPS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    RESULT = 2'd2
  } fsm_state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester after last_grant wins,
// searching upward with wrap-around, so the previous winner is served last.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any_req
);

  // Rotated priority scan; walking from the farthest candidate back toward
  // last_grant+1 lets the nearest requester overwrite the others.
  always_comb begin : scan
    int c;
    // NOTE: every signal written here gets a default first, so no path can leave a latch.
    c         = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    for (int k = NUM_CH; k >= 1; k--) begin
      c = int'(last_grant) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (req[c[CH_W-1:0]]) grant_idx = c[CH_W-1:0];
    end
    if (enable && any_req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shares one serial FIR MAC engine between NUM_CH sample channels:
// grants one sample round-robin, walks the taps, then offers the result.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int CH_W     = idx_width(NUM_CH),
  parameter int TAP_W    = idx_width(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  output logic [CH_W-1:0]   sel_ch,
  output logic              shift_en,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              mac_en,
  output logic              acc_clear,
  output logic              acc_last,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  fsm_state_e        state;
  logic [TAP_W-1:0]  tap;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   sel_ch_q;
  logic              out_valid_q;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_req;
  logic              arb_en;
  logic              accept;
  logic              in_mac;

  // Requests are only honoured while idle, enabled and out of reset.
  assign arb_en = enable && !reset && (state == IDLE);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  // The grant goes only to a requesting channel, so a grant is a transfer.
  assign accept    = arb_en && any_req;
  assign in_mac    = enable && (state == MAC);

  assign in_ready  = grant;
  assign shift_en  = accept;
  assign sel_ch    = accept ? grant_idx : sel_ch_q;
  assign tap_idx   = tap;
  assign mac_en    = in_mac;
  assign acc_clear = in_mac && (tap == '0);
  assign acc_last  = in_mac && (tap == LAST_TAP);
  assign out_valid = out_valid_q;
  assign out_ch    = sel_ch_q;
  assign busy      = (state != IDLE);

  // Scheduler FSM: accept a sample, run one tap per enabled cycle, hold the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tap         <= '0;
      last_grant  <= CH_W'(NUM_CH - 1);
      sel_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (enable) begin
      // NOTE: all state updates are non-blocking so every branch sees this cycle's values.
      case (state)
        IDLE: begin
          if (accept) begin
            sel_ch_q   <= grant_idx;
            last_grant <= grant_idx;
            tap        <= '0;
            state      <= MAC;
          end
        end
        MAC: begin
          if (tap == LAST_TAP) begin
            tap         <= '0;
            out_valid_q <= 1'b1;
            state       <= RESULT;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: a transaction-level reference
// model checks every output each cycle, directed sequences check timing.
module tb_fir_mac_scheduler;

  localparam int NUM_CH   = 4;
  localparam int NUM_TAPS = 8;
  localparam int CH_W     = 2;
  localparam int TAP_W    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_ready;
  logic [CH_W-1:0]   sel_ch;
  logic              shift_en;
  logic [TAP_W-1:0]  tap_idx;
  logic              mac_en;
  logic              acc_clear;
  logic              acc_last;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic              out_ready;
  logic              busy;

  always #5 clk = ~clk;

  fir_mac_scheduler #(
    .NUM_CH   (NUM_CH),
    .NUM_TAPS (NUM_TAPS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_ch    (sel_ch),
    .shift_en  (shift_en),
    .tap_idx   (tap_idx),
    .mac_en    (mac_en),
    .acc_clear (acc_clear),
    .acc_last  (acc_last),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: phase -1 waits for a sample, 0..NUM_TAPS-1 is the tap
  // being computed, NUM_TAPS means a finished result is on offer.
  int m_phase;
  int m_last;
  int m_owner;

  // Observation log, cleared per directed sequence.
  int acc_q[$];
  int acc_cyc_q[$];
  int res_q[$];
  int mac_cnt, clear_cyc, last_cyc, ov_cyc, ov_ch, ov_cnt, ov_chg;
  int rdy_bp, hs_cyc, gap_cnt;
  bit ov_seen;

  typedef struct {
    logic [NUM_CH-1:0] req;
    int                exp_ch;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_winner(input logic [NUM_CH-1:0] req, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (req[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic clear_log();
    acc_q.delete();
    acc_cyc_q.delete();
    res_q.delete();
    mac_cnt   = 0;
    clear_cyc = -1;
    last_cyc  = -1;
    ov_cyc    = -1;
    ov_ch     = -1;
    ov_cnt    = 0;
    ov_chg    = 0;
    rdy_bp    = 0;
    hs_cyc    = -1;
    gap_cnt   = 0;
    ov_seen   = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int   win;
    bit   idle_go;
    bit   in_tap;
    bit   mac_on;
    @(negedge clk);
    win     = pick_winner(in_valid, m_last);
    idle_go = (m_phase < 0) && enable && (win >= 0);
    in_tap  = (m_phase >= 0) && (m_phase < NUM_TAPS);
    mac_on  = enable && in_tap;

    check("in_ready",  int'(in_ready),  idle_go ? (1 << win) : 0);
    check("shift_en",  int'(shift_en),  int'(idle_go));
    check("sel_ch",    int'(sel_ch),    idle_go ? win : m_owner);
    check("tap_idx",   int'(tap_idx),   in_tap ? m_phase : 0);
    check("mac_en",    int'(mac_en),    int'(mac_on));
    check("acc_clear", int'(acc_clear), int'(mac_on && m_phase == 0));
    check("acc_last",  int'(acc_last),  int'(mac_on && m_phase == NUM_TAPS - 1));
    check("out_valid", int'(out_valid), int'(m_phase == NUM_TAPS));
    check("busy",      int'(busy),      int'(m_phase >= 0));
    if (m_phase == NUM_TAPS) check("out_ch", int'(out_ch), m_owner);

    if (shift_en) begin
      acc_q.push_back(int'(sel_ch));
      acc_cyc_q.push_back(cyc);
    end
    if (mac_en) mac_cnt++;
    if (acc_clear) clear_cyc = cyc;
    if (acc_last) last_cyc = cyc;
    if (!enable && busy && tap_idx == TAP_W'(4)) gap_cnt++;
    if (out_valid) begin
      ov_cnt++;
      if (in_ready != '0) rdy_bp++;
      if (!ov_seen) begin
        ov_seen = 1'b1;
        ov_cyc  = cyc;
        ov_ch   = int'(out_ch);
      end else if (int'(out_ch) != ov_ch) begin
        ov_chg++;
      end
      if (out_ready && enable) begin
        res_q.push_back(int'(out_ch));
        hs_cyc = cyc;
      end
    end

    @(posedge clk);
    cyc++;
    if (enable) begin
      if (idle_go) begin
        m_phase = 0;
        m_owner = win;
        m_last  = win;
      end else if (in_tap) begin
        m_phase++;
      end else if (m_phase == NUM_TAPS && out_ready) begin
        m_phase = -1;
      end
    end
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_in_ready",  int'(in_ready),  0);
    check("rst_shift_en",  int'(shift_en),  0);
    check("rst_sel_ch",    int'(sel_ch),    0);
    check("rst_tap_idx",   int'(tap_idx),   0);
    check("rst_mac_en",    int'(mac_en),    0);
    check("rst_acc_clear", int'(acc_clear), 0);
    check("rst_acc_last",  int'(acc_last),  0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch",    int'(out_ch),    0);
    check("rst_busy",      int'(busy),      0);
    m_phase = -1;
    m_last  = NUM_CH - 1;
    m_owner = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Timing of one logged job, with `gap` disabled cycles inside the tap run.
  task automatic check_job(input string tag, input int exp_ch, input int gap);
    check({tag, "_accepts"}, acc_q.size(), 1);
    if (acc_q.size() >= 1) begin
      check({tag, "_grant_ch"}, acc_q[0], exp_ch);
      check({tag, "_clear_ofs"}, clear_cyc - acc_cyc_q[0], 1);
      check({tag, "_last_ofs"}, last_cyc - acc_cyc_q[0], NUM_TAPS + gap);
      check({tag, "_ov_ofs"}, ov_cyc - acc_cyc_q[0], NUM_TAPS + 1 + gap);
    end
    check({tag, "_mac_pulses"}, mac_cnt, NUM_TAPS);
    check({tag, "_out_ch"}, ov_ch, exp_ch);
    check({tag, "_results"}, res_q.size(), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{req: 4'b1010, exp_ch: 1};
    vecs[1] = '{req: 4'b1010, exp_ch: 3};
    vecs[2] = '{req: 4'b1010, exp_ch: 1};
    vecs[3] = '{req: 4'b1111, exp_ch: 2};
    vecs[4] = '{req: 4'b0001, exp_ch: 0};
    vecs[5] = '{req: 4'b1001, exp_ch: 3};
    vecs[6] = '{req: 4'b0100, exp_ch: 2};
    vecs[7] = '{req: 4'b1011, exp_ch: 3};

    reset     = 1'b1;
    enable    = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
    clear_log();
    do_reset();

    // Single channel request on ch2.
    clear_log();
    repeat (2) step();
    in_valid = 4'b0100;
    step();
    in_valid = '0;
    repeat (10) step();
    check_job("single", 2, 0);

    // Table of request patterns, starting from the reset pointer.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_log();
      in_valid = vecs[i].req;
      step();
      in_valid = '0;
      repeat (10) step();
      check_job($sformatf("vec%0d", i), vecs[i].exp_ch, 0);
    end

    // All channels requesting continuously with the consumer always ready.
    do_reset();
    clear_log();
    in_valid = '1;
    repeat (50) step();
    in_valid = '0;
    check("rr_accepts", acc_q.size(), 5);
    check("rr_results", res_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < acc_q.size()) check($sformatf("rr_grant%0d", i), acc_q[i], i % NUM_CH);
      if (i < res_q.size()) check($sformatf("rr_out_ch%0d", i), res_q[i], i % NUM_CH);
      if (i > 0 && i < acc_cyc_q.size())
        check($sformatf("rr_spacing%0d", i), acc_cyc_q[i] - acc_cyc_q[i-1], NUM_TAPS + 2);
    end

    // Backpressure: result held for 20 cycles while every channel requests.
    clear_log();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    step();
    in_valid = '1;
    repeat (NUM_TAPS + 20) step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = '0;
    check("bp_ov_cycles", ov_cnt, 21);
    check("bp_out_ch", ov_ch, 1);
    check("bp_out_ch_changes", ov_chg, 0);
    check("bp_in_ready_in_result", rdy_bp, 0);
    check("bp_accepts", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      check("bp_first_ch", acc_q[0], 1);
      check("bp_next_ch", acc_q[1], 2);
      check("bp_regrant_gap", acc_cyc_q[1] - hs_cyc, 1);
    end
    repeat (10) step();

    // Enable dropped for three cycles while tap 4 is pending.
    clear_log();
    in_valid = 4'b0001;
    step();
    in_valid = '0;
    repeat (4) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (6) step();
    check("gap_frozen_tap", gap_cnt, 3);
    check_job("gap", 0, 3);

    // Reset in the middle of the tap run discards the job.
    clear_log();
    in_valid = 4'b1000;
    step();
    in_valid = '0;
    repeat (5) step();
    check("pre_reset_tap", int'(tap_idx), 5);
    check("pre_reset_busy", int'(busy), 1);
    do_reset();
    check("reset_no_result", ov_cnt, 0);
    clear_log();
    in_valid = '1;
    step();
    in_valid = '0;
    check("post_reset_accepts", acc_q.size(), 1);
    if (acc_q.size() >= 1) check("post_reset_grant", acc_q[0], 0);
    repeat (10) step();

    // Random traffic against the reference model.
    do_reset();
    repeat (3000) begin
      enable    = ($urandom_range(0, 99) < 85);
      in_valid  = NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
